// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS controller.
// Holds the FSM state codes, the opcode/funct values and the mux-select codes.
// It also defines the decoded instruction-class record passed from
// mc_ctrl_decode to mc_ctrl.
package mc_ctrl_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_RS  = 2'd3;

  localparam logic [1:0] ALUB_RT  = 2'd0;
  localparam logic [1:0] ALUB_SEXT = 2'd1;
  localparam logic [1:0] ALUB_ZEXT = 2'd2;
  localparam logic [1:0] ALUB_LUI = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // One-hot instruction class; all-zero means unrecognised (executes as nop).
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
  } instr_class_t;

  // Classes that continue past DECODE into EXEC.
  function automatic logic needs_exec(input instr_class_t c);
    return c.addu | c.subu | c.ori | c.lui | c.lw | c.sw | c.beq;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the controller and the shared datapath.
//   master (controller): drives enables, selects, state, retire and
//                        instr_cnt; reads opcode, funct and zero.
//   slave  (datapath):   the reverse direction.
interface mc_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pc_we;
  logic        ir_we;
  logic        reg_we;
  logic        mem_we;
  logic [1:0]  npc_sel;
  logic [1:0]  alu_b_sel;
  logic [2:0]  alu_op;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic [2:0]  state;
  logic        retire;
  logic [31:0] instr_cnt;

  modport master (
    input  opcode, funct, zero,
    output pc_we, ir_we, reg_we, mem_we, npc_sel, alu_b_sel, alu_op,
           reg_dst, wd_sel, state, retire, instr_cnt
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_we, ir_we, reg_we, mem_we, npc_sel, alu_b_sel, alu_op,
           reg_dst, wd_sel, state, retire, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational opcode/funct -> one-hot instruction class.
//   opcode : IR[31:26]
//   funct  : IR[5:0], meaningful only for R-type
//   cls    : one-hot class; all zero for an unrecognised encoding
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls      = '0;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls     = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB).
//   clk   : rising-edge clock
//   reset : synchronous active-high; forces FETCH and clears instr_cnt
//   bus   : mc_ctrl_if.master -- opcode/funct/zero in; PC/IR/GRF/DM enables,
//           npc/alu/reg_dst/wd selects, state, retire, instr_cnt out
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mc_ctrl_if.master  bus
);

  logic [2:0]   state_r;
  logic [2:0]   state_nx;
  logic [31:0]  cnt_r;
  instr_class_t cls;

  logic       pc_we, ir_we, reg_we, mem_we, retire;
  logic [1:0] npc_sel, alu_b_sel, reg_dst, wd_sel;
  logic [2:0] alu_op;

  mc_ctrl_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls)
  );

  always_comb begin
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    npc_sel   = NPC_PC4;
    alu_b_sel = ALUB_RT;
    alu_op    = ALU_ADD;
    reg_dst   = RD_RT;
    wd_sel    = WD_ALU;
    state_nx  = ST_FETCH;

    case (state_r)
      ST_FETCH: begin
        ir_we    = 1'b1;
        pc_we    = 1'b1;
        npc_sel  = NPC_PC4;
        state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        // Jumps finish here; anything unrecognised falls through as a nop.
        if (cls.j) begin
          pc_we   = 1'b1;
          npc_sel = NPC_J;
        end else if (cls.jal) begin
          pc_we   = 1'b1;
          npc_sel = NPC_J;
          reg_we  = 1'b1;
          reg_dst = RD_RA;
          wd_sel  = WD_PC;
        end else if (cls.jr) begin
          pc_we   = 1'b1;
          npc_sel = NPC_RS;
        end else if (needs_exec(cls)) begin
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls.addu || cls.subu) begin
          alu_b_sel = ALUB_RT;
          alu_op    = cls.subu ? ALU_SUB : ALU_ADD;
          state_nx  = ST_WB;
        end else if (cls.ori) begin
          alu_b_sel = ALUB_ZEXT;
          alu_op    = ALU_OR;
          state_nx  = ST_WB;
        end else if (cls.lui) begin
          alu_b_sel = ALUB_LUI;
          alu_op    = ALU_ADD;
          state_nx  = ST_WB;
        end else if (cls.lw || cls.sw) begin
          alu_b_sel = ALUB_SEXT;
          alu_op    = ALU_ADD;
          state_nx  = ST_MEM;
        end else if (cls.beq) begin
          // Branch taken only when rs - rt settles to zero this cycle.
          alu_b_sel = ALUB_RT;
          alu_op    = ALU_SUB;
          pc_we     = bus.zero;
          npc_sel   = NPC_BR;
        end
      end
      ST_MEM: begin
        if (cls.sw) begin
          mem_we = 1'b1;
        end else if (cls.lw) begin
          state_nx = ST_WB;
        end
      end
      ST_WB: begin
        reg_we = 1'b1;
        if (cls.addu || cls.subu) begin
          reg_dst = RD_RD;
          wd_sel  = WD_ALU;
        end else if (cls.lw) begin
          reg_dst = RD_RT;
          wd_sel  = WD_DM;
        end else begin
          reg_dst = RD_RT;
          wd_sel  = WD_ALU;
        end
      end
      default: state_nx = ST_FETCH;
    endcase

    retire = (state_r != ST_FETCH) && (state_nx == ST_FETCH);

    // A reset cycle abandons the instruction: nothing is written.
    if (reset) begin
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      reg_we    = 1'b0;
      mem_we    = 1'b0;
      npc_sel   = NPC_PC4;
      alu_b_sel = ALUB_RT;
      alu_op    = ALU_ADD;
      reg_dst   = RD_RT;
      wd_sel    = WD_ALU;
      retire    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      if (retire) cnt_r <= cnt_r + 32'd1;
    end
  end

  assign bus.pc_we     = pc_we;
  assign bus.ir_we     = ir_we;
  assign bus.reg_we    = reg_we;
  assign bus.mem_we    = mem_we;
  assign bus.npc_sel   = npc_sel;
  assign bus.alu_b_sel = alu_b_sel;
  assign bus.alu_op    = alu_op;
  assign bus.reg_dst   = reg_dst;
  assign bus.wd_sel    = wd_sel;
  assign bus.state     = state_r;
  assign bus.retire    = retire;
  assign bus.instr_cnt = cnt_r;

endmodule
